// File: rtl/alu_stream_unit.sv
// Streaming ALU responder: valid/ready request in, 2-entry in-order result FIFO out.
// Optional sticky overflow flag enabled by defining ALU_STREAM_STICKY_OVF_EN.
module alu_stream_unit #(
  parameter int NUMBITS = 8,
  parameter int TAGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] in_a,
  input  logic [NUMBITS-1:0] in_b,
  input  logic [2:0]         in_opcode,
  input  logic [TAGBITS-1:0] in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] out_result,
  output logic               out_carryout,
  output logic               out_overflow,
  output logic               out_zero,
`ifdef ALU_STREAM_STICKY_OVF_EN
  output logic               sticky_ovf,
  input  logic               sticky_clr,
`endif
  output logic [TAGBITS-1:0] out_tag
);

  localparam int MSB = NUMBITS - 1;

  typedef struct packed {
    logic [NUMBITS-1:0] result;
    logic               carryout;
    logic               overflow;
    logic               zero;
    logic [TAGBITS-1:0] tag;
  } rsp_t;

  // ---------------------------------------------------------------- ALU
  logic [NUMBITS:0]   sum_w, diff_w;
  logic [NUMBITS-1:0] res;
  logic               co, ov;
  rsp_t               rsp_new;

  assign sum_w  = {1'b0, in_a} + {1'b0, in_b};
  assign diff_w = {1'b0, in_a} - {1'b0, in_b};

  always_comb begin
    res = '0;
    co  = 1'b0;
    ov  = 1'b0;
    case (in_opcode)
      3'b000: begin
        res = sum_w[MSB:0];
        co  = sum_w[NUMBITS];
        ov  = sum_w[NUMBITS];
      end
      3'b001: begin
        res = sum_w[MSB:0];
        co  = sum_w[NUMBITS];
        ov  = (in_a[MSB] == in_b[MSB]) && (sum_w[MSB] != in_a[MSB]);
      end
      3'b010: begin
        // Top bit of the widened difference is the unsigned borrow.
        res = diff_w[MSB:0];
        co  = diff_w[NUMBITS];
        ov  = diff_w[NUMBITS];
      end
      3'b011: begin
        res = diff_w[MSB:0];
        co  = diff_w[NUMBITS];
        ov  = (in_a[MSB] != in_b[MSB]) && (diff_w[MSB] != in_a[MSB]);
      end
      3'b100: res = in_a & in_b;
      3'b101: res = in_a | in_b;
      3'b110: res = in_a ^ in_b;
      3'b111: begin
        res = {1'b0, in_a[MSB:1]};
        co  = in_a[0];
      end
      default: begin
        res = '0;
        co  = 1'b0;
        ov  = 1'b0;
      end
    endcase
  end

  always_comb begin
    rsp_new          = '0;
    rsp_new.result   = res;
    rsp_new.carryout = co;
    rsp_new.overflow = ov;
    rsp_new.zero     = (res == '0);
    rsp_new.tag      = in_tag;
  end

  // ---------------------------------------------------------------- FIFO
  rsp_t       mem [2];
  logic       wptr, rptr;
  logic [1:0] count;
  logic       push, pop;

  // in_ready only looks at registered count and reset, never at out_ready.
  assign in_ready  = !reset && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= rsp_new;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  rsp_t head;
  assign head         = mem[rptr];
  assign out_result   = head.result;
  assign out_carryout = head.carryout;
  assign out_overflow = head.overflow;
  assign out_zero     = head.zero;
  assign out_tag      = head.tag;

`ifdef ALU_STREAM_STICKY_OVF_EN
  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                  sticky_ovf <= 1'b0;
    else if (push && ov)        sticky_ovf <= 1'b1;
    else if (sticky_clr)        sticky_ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_stream_unit.sv
// Scoreboard bench for alu_stream_unit: driver pushes model results, negedge monitor checks.
module tb_alu_stream_unit;
  localparam int N = 8;
  localparam int T = 4;
  localparam int M = 1 << N;
  localparam int SMAX = (1 << (N - 1)) - 1;
  localparam int SMIN = -(1 << (N - 1));

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [N-1:0] in_a, in_b;
  logic [2:0]   in_opcode;
  logic [T-1:0] in_tag;
  logic         out_valid, out_ready;
  logic [N-1:0] out_result;
  logic         out_carryout, out_overflow, out_zero;
  logic [T-1:0] out_tag;
`ifdef ALU_STREAM_STICKY_OVF_EN
  logic sticky_ovf, sticky_clr;
  logic sticky_m = 1'b0;
`endif

  alu_stream_unit #(.NUMBITS(N), .TAGBITS(T)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carryout(out_carryout),
    .out_overflow(out_overflow), .out_zero(out_zero),
`ifdef ALU_STREAM_STICKY_OVF_EN
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
`endif
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int co;
    int ov;
    int z;
    int tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt = 0;
  bit   was_rst = 1'b0;
  bit   holding = 1'b0;
  exp_t held;
  bit   rnd_on = 1'b0;

  function automatic int to_s(int u);
    return (u > SMAX) ? u - M : u;
  endfunction

  // Reference computed from plain integer arithmetic.
  function automatic exp_t model(int op, int a, int b, int tag);
    exp_t e;
    int s;
    e.co = 0; e.ov = 0; e.r = 0; e.tag = tag;
    case (op)
      0: begin s = a + b; e.r = s % M; e.co = (s >= M); e.ov = e.co; end
      1: begin
        s = a + b; e.r = s % M; e.co = (s >= M);
        s = to_s(a) + to_s(b); e.ov = (s > SMAX || s < SMIN);
      end
      2: begin e.r = (a - b + M) % M; e.co = (a < b); e.ov = e.co; end
      3: begin
        e.r = (a - b + M) % M; e.co = (a < b);
        s = to_s(a) - to_s(b); e.ov = (s > SMAX || s < SMIN);
      end
      4: e.r = a & b;
      5: e.r = a | b;
      6: e.r = a ^ b;
      default: begin e.r = a / 2; e.co = a % 2; end
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: everything sampled at negedge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready_in_reset", int'(in_ready), 0);
      q.delete();
      cnt = 0;
      was_rst = 1'b1;
      holding = 1'b0;
`ifdef ALU_STREAM_STICKY_OVF_EN
      sticky_m = 1'b0;
`endif
    end else begin
      exp_t e;
      bit   pushed_ov;
      if (was_rst) begin
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(out_result), 0);
        chk("rst_flags", int'({out_carryout, out_overflow, out_zero}), 0);
        chk("rst_tag", int'(out_tag), 0);
        was_rst = 1'b0;
      end
      chk("in_ready", int'(in_ready), int'(cnt != 2));
      chk("out_valid", int'(out_valid), int'(cnt != 0));
`ifdef ALU_STREAM_STICKY_OVF_EN
      chk("sticky_ovf", int'(sticky_ovf), int'(sticky_m));
`endif
      if (holding && out_valid) begin
        chk("stall_result", int'(out_result), held.r);
        chk("stall_tag", int'(out_tag), held.tag);
        chk("stall_flags", int'({out_carryout, out_overflow, out_zero}),
            (held.co << 2) | (held.ov << 1) | held.z);
      end
      holding = out_valid && !out_ready;
      held.r = int'(out_result); held.tag = int'(out_tag);
      held.co = int'(out_carryout); held.ov = int'(out_overflow); held.z = int'(out_zero);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_response", int'(out_tag), -1);
        end else begin
          e = q.pop_front();
          chk("result", int'(out_result), e.r);
          chk("carryout", int'(out_carryout), e.co);
          chk("overflow", int'(out_overflow), e.ov);
          chk("zero", int'(out_zero), e.z);
          chk("tag", int'(out_tag), e.tag);
        end
        cnt--;
      end
      pushed_ov = 1'b0;
      if (in_valid && in_ready) begin
        e = model(int'(in_opcode), int'(in_a), int'(in_b), int'(in_tag));
        q.push_back(e);
        pushed_ov = (e.ov != 0);
        cnt++;
      end
`ifdef ALU_STREAM_STICKY_OVF_EN
      if (pushed_ov)       sticky_m = 1'b1;
      else if (sticky_clr) sticky_m = 1'b0;
`endif
    end
  end

  // Called at posedge+1; leaves in_valid high so calls chain back-to-back.
  task automatic send(input int op, input int a, input int b, input int tag);
    bit acc;
    in_valid = 1'b1; in_opcode = op[2:0]; in_a = a[N-1:0]; in_b = b[N-1:0]; in_tag = tag[T-1:0];
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    checks++; errors++;
    $display("FAIL send_timeout: got in_ready=0 expected acceptance of tag %0h", tag);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_a = N'($urandom); in_b = N'($urandom); in_opcode = 3'($urandom); in_tag = T'($urandom);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_opcode = '0; in_tag = '0;
    out_ready = 1'b1;
`ifdef ALU_STREAM_STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed arithmetic corners
    send(0, 'hFF, 'h01, 1);
    send(1, 'h7F, 'h01, 2);
    send(3, 'h80, 'h01, 3);
    send(2, 'h03, 'h05, 4);
    send(7, 'h81, 'h00, 5);
    idle(3);

    // Backpressure: third request waits until the consumer drains
    out_ready = 1'b0;
    fork
      begin send(4, 'hF0, 'h3C, 1); send(5, 'hF0, 'h3C, 2); send(6, 'hF0, 'h3C, 3); end
      begin repeat (6) @(posedge clk); #1 out_ready = 1'b1; end
    join
    idle(4);

    // Steady state at count=1 with simultaneous push and pop
    out_ready = 1'b0;
    send(4, 'hF0, 'h3C, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(4 + (i % 3), 'hF0, 'h3C, i + 1);
    idle(3);

    // Reset with a full FIFO
    out_ready = 1'b0;
    send(0, 'h80, 'h80, 7);
    send(1, 'h40, 'h40, 8);
    idle(1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Random traffic with random backpressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_STREAM_STICKY_OVF_EN
          sticky_clr = ($urandom_range(0, 7) == 0);
`endif
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom_range(0, 7), $urandom_range(0, M - 1), $urandom_range(0, M - 1), i % (1 << T));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        rnd_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_stream_unit.md
Name: alu_stream_unit

Overview:
Streaming responder for the lab ALU operation set.
- Accepts {A, B, opcode, tag} requests on a valid/ready input channel.
- Computes result and flags, and queues them in a 2-entry result FIFO.
- Returns them on a valid/ready output channel, in order.
- Sits between a stimulus/checker initiator (bench or sequencer) and downstream consumers; lets back-to-back ALU ops run with backpressure.

Parameters:
NUMBITS, 8, operand/result width (>=2)
TAGBITS, 4, width of the request tag carried through unchanged (>=1)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
in_valid  input  1  request present
in_ready  output  1  unit can accept request this cycle
in_a  input  NUMBITS  operand A
in_b  input  NUMBITS  operand B
in_opcode  input  3  operation select
in_tag  input  TAGBITS  request tag
out_valid  output  1  response present at FIFO head
out_ready  input  1  consumer accepts response
out_result  output  NUMBITS  result
out_carryout  output  1  carry/borrow flag
out_overflow  output  1  overflow flag
out_zero  output  1  result == 0
out_tag  output  TAGBITS  tag of the request that produced this response

Behaviour:
- Opcodes:
  - 000 unsigned add: carryout = bit NUMBITS of A+B; overflow = carryout.
  - 001 signed add: carryout = raw carry; overflow = operand signs equal and result sign differs.
  - 010 unsigned sub A-B: carryout = borrow (A<B unsigned); overflow = borrow.
  - 011 signed sub A-B: carryout = borrow; overflow = signs of A and B differ and result sign differs from A.
  - 100 AND, 101 OR, 110 XOR: carryout = overflow = 0.
  - 111 DIV2 = logical shift right A by 1, B ignored: carryout = A[0]; overflow = 0.
  - All arithmetic wraps modulo 2^NUMBITS.
- Zero flag: zero = (result == 0) for every opcode.
- Handshakes:
  - Input transfer when in_valid && in_ready at a rising edge.
  - Output transfer when out_valid && out_ready at a rising edge.
  - Payload inputs may change freely while in_valid is low.
  - out_* payload is held stable while out_valid && !out_ready.
- FIFO:
  - 2 entries, count 0..2.
  - in_ready = (count != 2), registered-state driven, with no combinational path from out_ready.
  - out_valid = (count != 0).
- Latency: request accepted at edge N appears on out_* with out_valid=1 after edge N if the FIFO was empty. There is no same-cycle bypass.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes head after the pop.
  - count 0: no pop is possible; count becomes 1.
  - count 2: push is blocked by in_ready=0; a pop still occurs and count becomes 1.
- Ordering: strictly in order; tags are returned unmodified.
- Pointer wrap: write and read pointers are 1 bit each and toggle on push/pop.
- Reset (synchronous, including mid-stream):
  - count=0, both pointers=0, in_ready=1 on the cycle after reset.
  - out_valid=0; out_result, out_carryout, out_overflow, out_zero, out_tag = 0.
  - Pending entries are discarded.
  - While reset is high, in_ready=0 and no transfer occurs.
- Undriven opcode X is don't-care; state and handshakes never depend on payload.

Optional Feature:
- Macro: ALU_STREAM_STICKY_OVF_EN.
- When defined:
  - Adds output sticky_ovf (1 bit) and input sticky_clr (1 bit).
  - sticky_ovf sets on any accepted request whose computed overflow=1 and stays set until sticky_clr=1 or reset.
  - If set and clear occur in the same cycle, set wins.
- When undefined: neither port exists and the logic is absent; all other behaviour is identical.

Test Plan:
1. Reset, then request 000 A=FF B=01 tag=1 with out_ready=1 -> next cycle out_valid=1, result=00, zero=1, carryout=1, overflow=1, tag=1.
2. Request 001 A=7F B=01 -> result=80, overflow=1, carryout=0, zero=0. Request 011 A=80 B=01 -> result=7F, overflow=1, carryout=0.
3. Request 010 A=03 B=05 -> result=FE, carryout=1; request 111 A=81 -> result=40, carryout=1, overflow=0.
4. Hold out_ready=0, push tags 1,2,3 on consecutive cycles -> tags 1,2 accepted, in_ready=0 after the 2nd, tag 3 held. Release out_ready -> responses in order 1,2,3, out payload stable while stalled.
5. count=1, in_valid=1 and out_ready=1 every cycle for 10 cycles (AND/OR/XOR with A=F0 B=3C -> 30/FC/CC) -> one response per cycle, count stays 1, no loss or duplication.
6. Assert reset with count=2 -> next cycle out_valid=0, all out_* = 0, in_ready=1; with the macro, sticky_ovf cleared.
